// File: rtl/ms_delay_arbiter.sv
// rtl/ms_delay_arbiter.sv - round-robin owner of the shared 1 ms tick timer; counts ticks and pulses done
// Optional MS_DELAY_ABORT_EN: owner dropping req in ARM/WAIT releases the timer without a done pulse.
module ms_delay_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] delay_ms,
  input  logic                     timer_tick,
  output logic                     timer_enable,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ARM, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   owner, owner_nxt, last;
  logic [CNT_W-1:0]   remain;
  logic [CNT_W-1:0]   delay_arr [NUM_REQ];
  logic [NUM_REQ-1:0] owner_hot, grant_nxt, done_nxt;
  logic               timer_enable_nxt, busy_nxt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_delay
    assign delay_arr[i] = delay_ms[i*CNT_W +: CNT_W];
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      owner        <= '0;
      last         <= IDX_W'(NUM_REQ - 1);
      remain       <= '0;
      timer_enable <= 1'b0;
      grant        <= '0;
      done         <= '0;
      busy         <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (state == ARM)
        remain <= delay_arr[owner];
      else if (state == WAIT && timer_tick && remain != '0)
        remain <= remain - 1'b1;
      // Completion and abort both hand priority past the owner.
      if (state != IDLE && state_nxt == IDLE)
        last <= owner;
      timer_enable <= timer_enable_nxt;
      grant        <= grant_nxt;
      done         <= done_nxt;
      busy         <= busy_nxt;
    end
  end

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    found     = 1'b0;
    cand      = '0;
    state_nxt = state;
    owner_nxt = owner;
    unique case (state)
      IDLE: begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          cand = IDX_W'((int'(last) + k) % NUM_REQ);
          if (!found && req[cand]) begin
            found     = 1'b1;
            owner_nxt = cand;
          end
        end
        if (found)
          state_nxt = ARM;
      end
      ARM:  state_nxt = (delay_arr[owner] == '0) ? DONE : WAIT;
      WAIT: if (timer_tick && remain == CNT_W'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
    endcase
`ifdef MS_DELAY_ABORT_EN
    if ((state == ARM || state == WAIT) && !req[owner])
      state_nxt = IDLE;
`endif
  end

  // Outputs are precomputed from the next state so every port comes straight from a flop.
  always_comb begin
    owner_hot            = '0;
    owner_hot[owner_nxt] = 1'b1;
    grant_nxt            = (state_nxt == ARM || state_nxt == WAIT) ? owner_hot : '0;
    done_nxt             = (state_nxt == DONE) ? owner_hot : '0;
    timer_enable_nxt     = (state_nxt == WAIT);
    busy_nxt             = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_ms_delay_arbiter.sv
// tb/tb_ms_delay_arbiter.sv - table-driven and hand-sequenced checks of ms_delay_arbiter
module tb_ms_delay_arbiter;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic [3:0]  req   = '0;
  logic [31:0] delay_ms = '0;
  logic        timer_tick = 1'b0;
  logic        timer_enable;
  logic [3:0]  grant, done;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  ms_delay_arbiter #(.NUM_REQ(4), .CNT_W(8)) dut (
    .clock(clock), .rst(rst), .req(req), .delay_ms(delay_ms),
    .timer_tick(timer_tick), .timer_enable(timer_enable),
    .grant(grant), .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] dly;
    logic        tick;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        en;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic [3:0] rq, logic [31:0] d, logic t,
                              logic [3:0] g, logic [3:0] dn, logic e, logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.dly = d; v.tick = t;
    v.grant = g; v.done = dn; v.en = e; v.busy = b;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_out(string tag, logic [3:0] g, logic [3:0] dn, logic e, logic b);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".done"},  32'(done),  32'(dn));
    chk({tag, ".en"},    32'(timer_enable), 32'(e));
    chk({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  initial begin
    // Single requester, delay 3; tick in ARM and in IDLE must be ignored.
    add(1, 4'h1, 32'h3, 0, 4'h1, 4'h0, 0, 1);
    add(1, 4'h1, 32'h3, 1, 4'h1, 4'h0, 1, 1);
    add(1, 4'h1, 32'h3, 0, 4'h1, 4'h0, 1, 1);
    add(1, 4'h1, 32'h3, 1, 4'h1, 4'h0, 1, 1);
    add(1, 4'h1, 32'h3, 0, 4'h1, 4'h0, 1, 1);
    add(1, 4'h1, 32'h3, 1, 4'h1, 4'h0, 1, 1);
    add(1, 4'h1, 32'h3, 1, 4'h0, 4'h1, 0, 1);
    add(1, 4'h0, 32'h3, 1, 4'h0, 4'h0, 0, 0);
    add(0, 4'h0, 32'h0, 0, 4'h0, 4'h0, 0, 0);
    // All four requesting with delay 1: rotation 0,1,2,3 then back to 0.
    for (int i = 0; i < 4; i++) begin
      add(1, 4'hF, 32'h01010101, 0, 4'(1 << i), 4'h0, 0, 1);
      add(1, 4'hF, 32'h01010101, 0, 4'(1 << i), 4'h0, 1, 1);
      add(1, 4'hF, 32'h01010101, 1, 4'h0, 4'(1 << i), 0, 1);
      add(1, 4'hF, 32'h01010101, 0, 4'h0, 4'h0, 0, 0);
    end
    add(1, 4'hF, 32'h01010101, 0, 4'h1, 4'h0, 0, 1);
    add(1, 4'hF, 32'h01010101, 0, 4'h1, 4'h0, 1, 1);
    add(1, 4'hF, 32'h01010101, 1, 4'h0, 4'h1, 0, 1);
    add(1, 4'h0, 32'h01010101, 0, 4'h0, 4'h0, 0, 0);
    // Zero delay on requester 2 with ticks present throughout.
    add(1, 4'h4, 32'h0, 1, 4'h4, 4'h0, 0, 1);
    add(1, 4'h4, 32'h0, 1, 4'h0, 4'h4, 0, 1);
    add(1, 4'h0, 32'h0, 1, 4'h0, 4'h0, 0, 0);

    #2 rst = 1'b0;
    #10;
    chk_out("reset", 4'h0, 4'h0, 0, 0);
    step();
    rst = 1'b1;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req;
      delay_ms = vecs[i].dly; timer_tick = vecs[i].tick;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].done, vecs[i].en, vecs[i].busy);
    end
    timer_tick = 0;

    // Asynchronous reset in the middle of a 5 ms wait, then a clean delay of 2.
    req = 4'h8; delay_ms = 32'h05000000;
    step(); chk_out("rstwait.arm", 4'h8, 4'h0, 0, 1);
    step(); chk_out("rstwait.wait", 4'h8, 4'h0, 1, 1);
    #3 rst = 1'b0;
    #1 chk_out("rstwait.async", 4'h0, 4'h0, 0, 0);
    step();
    rst = 1'b1; req = 4'h2; delay_ms = 32'h00000200;
    step(); chk_out("post.arm", 4'h2, 4'h0, 0, 1);
    step(); chk_out("post.wait", 4'h2, 4'h0, 1, 1);
    timer_tick = 1;
    step(); chk_out("post.tick1", 4'h2, 4'h0, 1, 1);
    step(); chk_out("post.done", 4'h0, 4'h2, 0, 1);
    timer_tick = 0; req = 4'h0;
    step(); chk_out("post.idle", 4'h0, 4'h0, 0, 0);

    // Owner 1 drops its request mid-wait with 4 ms remaining while 2 is pending.
    rst = 1'b0;
    step();
    rst = 1'b1; req = 4'h6; delay_ms = 32'h00010400;
    step(); chk_out("drop.arm", 4'h2, 4'h0, 0, 1);
    step(); chk_out("drop.wait", 4'h2, 4'h0, 1, 1);
    req = 4'h4;
    step();
`ifdef MS_DELAY_ABORT_EN
    chk_out("drop.abort", 4'h0, 4'h0, 0, 0);
`else
    chk_out("drop.hold", 4'h2, 4'h0, 1, 1);
    timer_tick = 1;
    for (int t = 1; t <= 3; t++) begin
      step(); chk_out($sformatf("drop.tick%0d", t), 4'h2, 4'h0, 1, 1);
    end
    step(); chk_out("drop.done", 4'h0, 4'h2, 0, 1);
    timer_tick = 0;
    step(); chk_out("drop.idle", 4'h0, 4'h0, 0, 0);
`endif
    step(); chk_out("next.arm", 4'h4, 4'h0, 0, 1);
    step(); chk_out("next.wait", 4'h4, 4'h0, 1, 1);
    timer_tick = 1;
    step(); chk_out("next.done", 4'h0, 4'h4, 0, 1);
    timer_tick = 0; req = 4'h0;
    step(); chk_out("next.idle", 4'h0, 4'h0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ms_delay_arbiter.md
# ms_delay_arbiter

Shares the single 1 ms tick timer among several LCD-path requesters (power-up sequencer, command writer, refresh logic) that each need a millisecond-granular wait. Round-robin arbitration picks one requester, enables the timer, counts its 1 ms indications down from the requested delay, and returns a one-cycle done pulse. It sits between the timer instance and the LCD control FSMs. It is the only block that drives the timer's enable.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 8, width of each delay field in ms (max delay 2^CNT_W-1 ms)

- clock  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester delay request, level, held until done (or abort)
- delay_ms  in  NUM_REQ*CNT_W  requester i's delay at bits [i*CNT_W +: CNT_W]
- timer_tick  in  1  one-cycle 1 ms indication from the timer
- timer_enable  out  1  drives timer EnableCount
- grant  out  NUM_REQ  one-hot owner of the timer, zero when idle
- done  out  NUM_REQ  one-cycle pulse on owner's bit when its delay expires
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, ARM, WAIT, DONE.
- IDLE: timer_enable=0, grant=0. If any req bit is set, choose the winner by round robin, starting at index (last+1) mod NUM_REQ. Go to ARM.
- ARM: grant[w]=1. Latch delay_ms[w] into remain (CNT_W bits).
  - If the latched value is 0, go to DONE.
  - Otherwise go to WAIT.
- WAIT: grant[w]=1, timer_enable=1.
  - Each timer_tick decrements remain.
  - A tick while remain==1 goes to DONE.
  - remain never wraps below 0.
- DONE: timer_enable=0, grant=0, done[w]=1 for exactly this cycle. last<=w. Go to IDLE.
- Because DONE and IDLE both hold timer_enable low, the timer sees at least 2 low cycles between consecutive grants and restarts its count cleanly.
- timer_tick outside WAIT is ignored.
- The delay_ms value is sampled only in ARM. Later changes have no effect on the current delay.
- req bits of non-owners may change freely. They are only evaluated in IDLE.
- Reset (any time, including mid-WAIT): state=IDLE, remain=0, last=NUM_REQ-1 (so index 0 has first priority), and all outputs 0. No done pulse is produced for the interrupted delay.

## Timing
- Cycle-level, with req[i] first seen high at IDLE edge T:
  - ARM at T+1 (grant visible)
  - WAIT at T+2 (timer_enable visible)
  - done visible in the cycle after the Nth tick
- Zero delay: done is high in cycle T+2, grant is high only in T+1, and timer_enable is never asserted.
- Turnaround: a new grant appears no earlier than 2 cycles after done (DONE to IDLE to ARM).
- Simultaneous requests resolve purely by round-robin order. A requester re-asserting immediately after its own done is served last among those pending.
- All outputs are registered.

## Configuration
- MS_DELAY_ABORT_EN:
  - Defined: in ARM or WAIT, if req[w] drops, go directly to IDLE. timer_enable and grant fall on the next edge, no done pulse is produced, and last<=w.
  - Undefined: req[w] is ignored after the grant. The delay always runs to completion and done[w] pulses.

## Test plan
- Reset then req=4'b0001, delay 3, inject 3 ticks 20 cycles apart -> grant=0001 from T+1; timer_enable high from T+2 until the 3rd tick; done[0] is one cycle after the 3rd tick; busy back to 0 two cycles later.
- req=4'b1111, all delays 1 -> grants in order 0,1,2,3, each with one done pulse. Then with req held, the next grant is 0 again.
- req[2] with delay 0 -> grant[2] for one cycle, done[2] next cycle, timer_enable never high, ticks ignored.
- rst pulled low during WAIT with remain=5 -> all outputs 0 asynchronously. After release, a fresh req[1] with delay 2 completes normally with no stale done.
- With MS_DELAY_ABORT_EN, drop req[1] mid-WAIT with remain=4 -> IDLE next cycle, no done[1], and pending req[2] granted 1 cycle later. Without the macro -> done[1] after 4 ticks.
- Tick coincident with ARM, or arriving in IDLE -> remain unchanged; done requires the full N ticks counted in WAIT.
